// File: rtl/m72_pkg.sv
// Shared M72 sample-path definitions: fetch FSM states and sample-ROM address geometry.
package m72_pkg;

  typedef enum logic [1:0] {
    ST_VALID = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_t;

  localparam int SAMPLE_ROM_AW     = 18;
  localparam int SAMPLE_ADDR_SHIFT = 5;
  localparam int SDR_AW            = 25;

endpackage

// File: rtl/mcu_sample_fetch_if.sv
// SDRAM-side port of the sample fetch stage: one toggle request/acknowledge channel.
interface mcu_sample_fetch_if;
  import m72_pkg::*;

  // A request is pending while sdr_req != sdr_ack. The master flips sdr_req with
  // sdr_addr valid and holds sdr_addr until the slave flips sdr_ack, which it does
  // with sdr_data already valid for that address. At most one request is pending.
  logic [SDR_AW-1:0] sdr_addr;
  logic              sdr_req;
  logic              sdr_ack;
  logic [15:0]       sdr_data;

  modport master (
    output sdr_addr,
    output sdr_req,
    input  sdr_ack,
    input  sdr_data
  );

  modport slave (
    input  sdr_addr,
    input  sdr_req,
    output sdr_ack,
    output sdr_data
  );

endinterface

// File: rtl/mcu_sample_fetch.sv
// Sample-ROM fetch stage behind the M72 sample MCU: owns the sample byte address and
// keeps sample_rom_data in step with it, stalling the MCU via sample_ready while fetching.
module mcu_sample_fetch
  import m72_pkg::*;
#(
  parameter int                ROM_AW   = SAMPLE_ROM_AW,
  parameter logic [SDR_AW-1:0] ROM_BASE = '0
) (
  input  logic              CLK_32M,
  input  logic              reset,
  input  logic [1:0]        sample_addr_wr,
  input  logic [7:0]        sample_addr,
  input  logic              sample_inc,
  output logic [7:0]        sample_rom_data,
  output logic              sample_ready,
  output logic [ROM_AW-1:0] dbg_addr,
  output fetch_state_t      dbg_state,
  mcu_sample_fetch_if.master sdr
);

  localparam int HI_LSB = SAMPLE_ADDR_SHIFT + 8;

  fetch_state_t      state_q, state_d;
  logic [ROM_AW-1:0] cur_q, cur_d;
  logic              dirty_q, dirty_d;
  logic              req_q, req_d;
  logic [SDR_AW-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              addr_event;
  logic              ack_match;
  logic [7:0]        sel_byte;

  assign addr_event = (|sample_addr_wr) | sample_inc;
  assign ack_match  = (sdr.sdr_ack == req_q);
  assign sel_byte   = addr_q[0] ? sdr.sdr_data[15:8] : sdr.sdr_data[7:0];

  // Latch writes take priority over an increment in the same cycle; a new event
  // in the ISSUE cycle re-arms dirty so the just-issued fetch will be discarded.
  always_comb begin : addr_update
    cur_d   = cur_q;
    dirty_d = dirty_q;
    if (state_q == ST_ISSUE) begin
      dirty_d = 1'b0;
    end
    if (sample_addr_wr[0]) begin
      cur_d[HI_LSB-1:SAMPLE_ADDR_SHIFT] = sample_addr;
      cur_d[SAMPLE_ADDR_SHIFT-1:0]      = '0;
      dirty_d                           = 1'b1;
    end else if (sample_addr_wr[1]) begin
      cur_d[ROM_AW-1:HI_LSB]       = sample_addr[ROM_AW-HI_LSB-1:0];
      cur_d[SAMPLE_ADDR_SHIFT-1:0] = '0;
      dirty_d                      = 1'b1;
    end else if (sample_inc) begin
      cur_d   = cur_q + ROM_AW'(1);
      dirty_d = 1'b1;
    end
  end

  always_comb begin : fetch_fsm
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      ST_VALID: begin
        // Leave VALID on the event itself so ready drops on the very next cycle.
        if (addr_event || dirty_q) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        addr_d  = ROM_BASE + SDR_AW'(cur_q);
        req_d   = ~req_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_match) begin
          if (dirty_q || addr_event) begin
            state_d = ST_ISSUE;
          end else begin
            data_d  = sel_byte;
            state_d = ST_VALID;
          end
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  // Reset parks req on the sampled ack so an ack for a pre-reset request is absorbed.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state_q <= ST_ISSUE;
      cur_q   <= '0;
      dirty_q <= 1'b1;
      req_q   <= sdr.sdr_ack;
      addr_q  <= ROM_BASE;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dirty_q <= dirty_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign sample_ready    = (state_q == ST_VALID);
  assign sample_rom_data = data_q;
  assign sdr.sdr_addr    = addr_q;
  assign sdr.sdr_req     = req_q;
  assign dbg_addr        = cur_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mcu_sample_fetch.sv
// Directed bench for mcu_sample_fetch with a toggle-handshake SDRAM model (6-cycle latency).
module tb_mcu_sample_fetch;
  import m72_pkg::*;

  localparam logic [24:0] BASE = 25'h010_0000;
  localparam int          LAT  = 6;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #15 clk = ~clk;

  logic [1:0]   wr    = 2'b00;
  logic [7:0]   wdata = 8'h00;
  logic         inc   = 1'b0;
  logic [7:0]   rom_data;
  logic         ready;
  logic [17:0]  dbg_addr;
  fetch_state_t dbg_state;

  mcu_sample_fetch_if sdr_bus ();

  mcu_sample_fetch #(
    .ROM_AW   (18),
    .ROM_BASE (BASE)
  ) dut (
    .CLK_32M         (clk),
    .reset           (reset),
    .sample_addr_wr  (wr),
    .sample_addr     (wdata),
    .sample_inc      (inc),
    .sample_rom_data (rom_data),
    .sample_ready    (ready),
    .dbg_addr        (dbg_addr),
    .dbg_state       (dbg_state),
    .sdr             (sdr_bus.master)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [24:0] exp_q[$];
  logic        sb_strict = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- SDRAM model ----------------
  logic        ack   = 1'b0;
  logic [15:0] mdata = 16'h0000;
  logic        busy  = 1'b0;
  int          cnt   = 0;
  int          n_req = 0;
  logic [24:0] req_addr = '0;
  logic [24:0] last_req = '0;

  assign sdr_bus.sdr_ack  = ack;
  assign sdr_bus.sdr_data = mdata;

  function automatic logic [15:0] rom_word(input logic [24:0] a);
    logic [24:0] off;
    off = a - BASE;
    return {off[16:9] ^ 8'hC3, off[8:1] ^ 8'h5A};
  endfunction

  always @(negedge clk) begin
    if (busy) begin
      if (cnt == 0) begin
        if (!reset) check_val("addr_hold", 32'(sdr_bus.sdr_addr), 32'(req_addr));
        mdata <= rom_word(req_addr);
        ack   <= ~ack;
        busy  <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (!reset && (sdr_bus.sdr_req !== ack)) begin
      busy     <= 1'b1;
      cnt      <= LAT - 1;
      req_addr <= sdr_bus.sdr_addr;
      last_req <= sdr_bus.sdr_addr;
      n_req    <= n_req + 1;
      if (sb_strict) begin
        if (exp_q.size() == 0) check_val("unexp_req", 32'(exp_q.size()), 32'd1);
        else check_val("req_addr", 32'(sdr_bus.sdr_addr), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_wr(input logic [1:0] sel, input logic [7:0] d);
    wr    = sel;
    wdata = d;
    @(negedge clk);
    wr    = 2'b00;
  endtask

  task automatic pulse_inc();
    inc = 1'b1;
    @(negedge clk);
    inc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val(tag, 32'(ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int n;
  int req0;

  initial begin
    @(negedge clk);
    idle(3);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_data", 32'(rom_data), 32'h00);
    check_val("rst_req_eq_ack", 32'(sdr_bus.sdr_req), 32'(ack));
    check_val("rst_sdr_addr", 32'(sdr_bus.sdr_addr), 32'(BASE));
    check_val("rst_dbg_addr", 32'(dbg_addr), 32'h0);

    // power-on fetch of address 0
    exp_q.push_back(BASE);
    reset = 1'b0;
    wait_ready("por_timeout", n);
    check_val("por_latency", n, 32'd8);
    check_val("por_data", 32'(rom_data), 32'h5A);
    check_val("por_nreq", n_req, 32'd1);
    idle(3);

    // low then high latch on consecutive cycles: intermediate fetch discarded
    exp_q.push_back(BASE + 25'h00240);
    exp_q.push_back(BASE + 25'h06240);
    req0 = n_req;
    pulse_wr(2'b01, 8'h12);
    check_val("lo_ready_drop", 32'(ready), 32'd0);
    pulse_wr(2'b10, 8'h03);
    wait_ready("lohi_timeout", n);
    check_val("lohi_dbg", 32'(dbg_addr), 32'h06240);
    check_val("lohi_data", 32'(rom_data), 32'h7A);
    check_val("lohi_nreq", n_req - req0, 32'd2);
    idle(10);

    // three spaced increments, odd addresses take the high byte
    exp_q.push_back(BASE + 25'h06241);
    pulse_inc();
    check_val("inc1_ready_drop", 32'(ready), 32'd0);
    check_val("inc1_state", 32'(dbg_state), 32'(ST_ISSUE));
    check_val("inc1_dbg", 32'(dbg_addr), 32'h06241);
    @(negedge clk);
    check_val("inc1_sdr_addr", 32'(sdr_bus.sdr_addr), 32'(BASE + 25'h06241));
    wait_ready("inc1_timeout", n);
    check_val("inc1_latency", n + 1, 32'd8);
    check_val("inc1_data", 32'(rom_data), 32'hF2);
    idle(11);
    exp_q.push_back(BASE + 25'h06242);
    pulse_inc();
    wait_ready("inc2_timeout", n);
    check_val("inc2_data", 32'(rom_data), 32'h7B);
    idle(12);
    exp_q.push_back(BASE + 25'h06243);
    pulse_inc();
    wait_ready("inc3_timeout", n);
    check_val("inc3_data", 32'(rom_data), 32'hF2);
    idle(5);

    // two increments while waiting: first ack dropped, one refetch at +2
    exp_q.push_back(BASE + 25'h06244);
    exp_q.push_back(BASE + 25'h06246);
    req0 = n_req;
    pulse_inc();
    idle(2);
    pulse_inc();
    idle(1);
    pulse_inc();
    wait_ready("wait_inc_timeout", n);
    check_val("wait_inc_dbg", 32'(dbg_addr), 32'h06246);
    check_val("wait_inc_data", 32'(rom_data), 32'h79);
    check_val("wait_inc_nreq", n_req - req0, 32'd2);
    idle(5);

    // latch write and increment together: the write wins
    exp_q.push_back(BASE + 25'h06660);
    wr    = 2'b01;
    wdata = 8'h33;
    inc   = 1'b1;
    @(negedge clk);
    wr    = 2'b00;
    inc   = 1'b0;
    check_val("wr_beats_inc_dbg", 32'(dbg_addr), 32'h06660);
    wait_ready("wr_inc_timeout", n);
    check_val("wr_beats_inc_data", 32'(rom_data), 32'h6A);
    idle(5);

    // walk to 3FFFF (high-latch bits 7:5 ignored), then wrap to 0
    sb_strict = 1'b0;
    pulse_wr(2'b01, 8'hFF);
    pulse_wr(2'b10, 8'hFF);
    check_val("hi_ignore_dbg", 32'(dbg_addr), 32'h3FFE0);
    for (int i = 0; i < 31; i++) pulse_inc();
    wait_ready("top_timeout", n);
    sb_strict = 1'b1;
    check_val("top_dbg", 32'(dbg_addr), 32'h3FFFF);
    check_val("top_req", 32'(last_req), 32'(BASE + 25'h3FFFF));
    check_val("top_data", 32'(rom_data), 32'h3C);
    idle(5);
    exp_q.push_back(BASE);
    pulse_inc();
    check_val("wrap_dbg", 32'(dbg_addr), 32'h00000);
    wait_ready("wrap_timeout", n);
    check_val("wrap_data", 32'(rom_data), 32'h5A);
    idle(5);

    // reset during WAIT; the in-flight ack lands while reset is held
    exp_q.push_back(BASE + 25'h00800);
    pulse_wr(2'b01, 8'h40);
    idle(2);
    check_val("mid_state", 32'(dbg_state), 32'(ST_WAIT));
    reset = 1'b1;
    idle(10);
    check_val("mid_rst_ready", 32'(ready), 32'd0);
    check_val("mid_rst_data", 32'(rom_data), 32'h00);
    check_val("mid_rst_req_eq_ack", 32'(sdr_bus.sdr_req), 32'(ack));
    check_val("mid_rst_dbg", 32'(dbg_addr), 32'h0);
    check_val("mid_rst_sdr_addr", 32'(sdr_bus.sdr_addr), 32'(BASE));
    exp_q.push_back(BASE);
    req0 = n_req;
    reset = 1'b0;
    wait_ready("mid_rst_timeout", n);
    check_val("mid_rst_latency", n, 32'd8);
    check_val("mid_rst_fetch_data", 32'(rom_data), 32'h5A);
    check_val("mid_rst_nreq", n_req - req0, 32'd1);
    idle(10);
    check_val("mid_rst_still_ready", 32'(ready), 32'd1);
    check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
